// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute-stage ALU and the ALU control block that
// produces aluCode: the 4-bit operation codes, the bit positions inside the
// 4-bit flags word, a packed view of that word, and a helper that says which
// codes count as real (non-noop, legal) operations.
// -----------------------------------------------------------------------------
package alu_pkg;

    // Operation codes as driven by ALU control.
    localparam logic [3:0] ALU_NOOP = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;

    // Bit positions inside the flags word {illegal, overflow, carry, zero}.
    localparam int unsigned FLAG_ZERO     = 0;
    localparam int unsigned FLAG_CARRY    = 1;
    localparam int unsigned FLAG_OVERFLOW = 2;
    localparam int unsigned FLAG_ILLEGAL  = 3;

    // Packed view of the flags word; field order matches the bit indices above.
    typedef struct packed {
        logic illegal;
        logic overflow;
        logic carry;
        logic zero;
    } alu_flags_t;

    // True for the codes that perform real work (add..slt). These are the
    // only codes that report a zero flag and advance the operation counter.
    function automatic logic is_counted(input logic [3:0] code);
        logic hit;
        case (code)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: hit = 1'b1;
            default:                                    hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage : alu_pkg

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational ALU datapath: maps (aluCode, opA, opB) to a result and
// the {illegal, overflow, carry, zero} flags. No state; the enclosing alu_exec
// registers the outputs and owns the handshake.
//
// Ports
//   aluCode  in   4      operation code (see alu_pkg)
//   opA/opB  in   WIDTH  operands (two's complement where signedness matters)
//   result   out  WIDTH  operation result
//   flags    out  4      {illegal, overflow, carry, zero}
//
// WIDTH must be at least 4.
// -----------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [3:0]       aluCode,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    // One extra bit on each arithmetic path exposes carry-out / borrow.
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic             slt_s;
    logic [WIDTH-1:0] res_s;
    alu_flags_t       fl_s;

    assign sum_s  = {1'b0, opA} + {1'b0, opB};
    // With a zero-extended subtraction the top bit is set exactly when
    // opA < opB unsigned, which is the borrow we report as carry.
    assign diff_s = {1'b0, opA} - {1'b0, opB};
    assign slt_s  = ($signed(opA) < $signed(opB)) ? 1'b1 : 1'b0;

    // Operation select and flag generation.
    always_comb begin
        res_s = {WIDTH{1'b0}};
        fl_s  = '0;
        case (aluCode)
            ALU_NOOP: begin
                res_s = {WIDTH{1'b0}};
            end
            ALU_ADD: begin
                res_s         = sum_s[WIDTH-1:0];
                fl_s.carry    = sum_s[WIDTH];
                // Signed overflow: same-sign operands, result sign differs.
                fl_s.overflow = (opA[WIDTH-1] == opB[WIDTH-1]) &&
                                (sum_s[WIDTH-1] != opA[WIDTH-1]);
            end
            ALU_SUB: begin
                res_s         = diff_s[WIDTH-1:0];
                fl_s.carry    = diff_s[WIDTH];
                // Signed overflow: opposite-sign operands, result sign
                // differs from the minuend.
                fl_s.overflow = (opA[WIDTH-1] != opB[WIDTH-1]) &&
                                (diff_s[WIDTH-1] != opA[WIDTH-1]);
            end
            ALU_AND: begin
                res_s = opA & opB;
            end
            ALU_OR: begin
                res_s = opA | opB;
            end
            ALU_SLT: begin
                res_s = {{(WIDTH-1){1'b0}}, slt_s};
            end
            default: begin
                res_s        = {WIDTH{1'b0}};
                fl_s.illegal = 1'b1;
            end
        endcase

        // Zero only reflects a real operation; noop/illegal report zero=0
        // even though their result is 0.
        if (is_counted(aluCode)) begin
            fl_s.zero = (res_s == {WIDTH{1'b0}}) ? 1'b1 : 1'b0;
        end else begin
            fl_s.zero = 1'b0;
        end
    end

    assign result = res_s;
    assign flags  = fl_s;

endmodule : alu_core

// File: rtl/alu_exec.sv
// -----------------------------------------------------------------------------
// alu_exec
// Execute-stage ALU with a valid/ready handshake on both sides and a single
// output register. An operation accepted at an edge is presented on the next
// cycle; while the consumer stalls the result is held. A transfer and a new
// accept can happen on the same edge, so a continuously ready consumer sees
// one result per cycle with no bubbles.
//
// Ports
//   clk        in   1      clock, all state updates on the rising edge
//   reset      in   1      synchronous active-high reset
//   in_valid   in   1      an operation is offered
//   in_ready   out  1      the offered operation is taken this cycle
//   aluCode    in   4      operation code (see alu_pkg)
//   opA/opB    in   WIDTH  operands
//   out_valid  out  1      result/flags are valid
//   out_ready  in   1      consumer takes the result this cycle
//   result     out  WIDTH  registered result
//   flags      out  4      registered {illegal, overflow, carry, zero}
//   op_count   out  16     completed add/sub/and/or/slt operations, saturating
// -----------------------------------------------------------------------------
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       aluCode,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic [15:0]      op_count
);

    // Output-register occupancy states.
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_d;
    logic [3:0]       flags_q;
    logic [3:0]       flags_d;
    logic [15:0]      op_count_q;
    logic [15:0]      op_count_d;

    logic             valid_s;
    logic             accept_s;
    logic             transfer_s;
    logic [WIDTH-1:0] alu_result_s;
    logic [3:0]       alu_flags_s;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .aluCode (aluCode),
        .opA     (opA),
        .opB     (opB),
        .result  (alu_result_s),
        .flags   (alu_flags_s)
    );

    assign valid_s = (state_q == ST_FULL) ? 1'b1 : 1'b0;

    // Ready whenever the register is free or being emptied this cycle.
    // Reset forces ready high so an upstream offer during reset completes
    // (and is dropped) instead of stalling on a not-yet-cleared register.
    assign in_ready   = reset | ~valid_s | out_ready;
    assign accept_s   = in_valid & in_ready & ~reset;
    assign transfer_s = valid_s & out_ready;

    // Occupancy FSM next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (transfer_s && !accept_s) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Output register load: only an accept replaces the held result; a bare
    // transfer leaves the stale value in place behind out_valid=0.
    always_comb begin
        if (accept_s) begin
            result_d = alu_result_s;
            flags_d  = alu_flags_s;
        end else begin
            result_d = result_q;
            flags_d  = flags_q;
        end
    end

    // Saturating count of accepted real operations.
    always_comb begin
        if (accept_s && is_counted(aluCode) && (op_count_q != 16'hFFFF)) begin
            op_count_d = op_count_q + 16'd1;
        end else begin
            op_count_d = op_count_q;
        end
    end

    // State, output register and counter with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            result_q   <= {WIDTH{1'b0}};
            flags_q    <= 4'b0000;
            op_count_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
            op_count_q <= op_count_d;
        end
    end

    assign out_valid = valid_s;
    assign result    = result_q;
    assign flags     = flags_q;
    assign op_count  = op_count_q;

endmodule : alu_exec

// File: tb/tb_alu_exec.sv
// -----------------------------------------------------------------------------
// tb_alu_exec
// Self-checking bench for alu_exec (WIDTH=16): directed vector table, random
// handshake traffic checked against an integer-arithmetic reference model and
// a scoreboard queue, plus hand-written backpressure/back-to-back/reset and
// counter saturation sequences.
// -----------------------------------------------------------------------------
module tb_alu_exec;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  aluCode;
    logic [15:0] opA;
    logic [15:0] opB;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [3:0]  flags;
    logic [15:0] op_count;

    int checks   = 0;
    int failures = 0;
    int cnt      = 0;

    logic [19:0] exp_q[$];

    typedef struct {
        logic [3:0]  code;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic [3:0]  f;
    } vec_t;

    vec_t tbl[13];

    alu_exec #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluCode   (aluCode),
        .opA       (opA),
        .opB       (opB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit counted(input logic [3:0] c);
        return (c >= 4'd1) && (c <= 4'd5);
    endfunction

    // Reference model in plain integer arithmetic on 16-bit operands.
    function automatic void model(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic [3:0] f);
        int ua, ub, sa, sb, t;
        bit cy, ov, il;
        ua = a;
        ub = b;
        sa = (ua >= 32768) ? ua - 65536 : ua;
        sb = (ub >= 32768) ? ub - 65536 : ub;
        cy = 1'b0; ov = 1'b0; il = 1'b0; t = 0;
        case (c)
            4'd0: t = 0;
            4'd1: begin
                t  = ua + ub;
                cy = (t > 65535);
                ov = (sa + sb > 32767) || (sa + sb < -32768);
            end
            4'd2: begin
                t  = ua - ub;
                cy = (ua < ub);
                ov = (sa - sb > 32767) || (sa - sb < -32768);
            end
            4'd3: t = ua & ub;
            4'd4: t = ua | ub;
            4'd5: t = (sa < sb) ? 1 : 0;
            default: begin
                t  = 0;
                il = 1'b1;
            end
        endcase
        r = 16'(t);
        f = {il, ov, cy, counted(c) && (r == 16'd0)};
    endfunction

    // One random handshake cycle with scoreboard bookkeeping.
    task automatic rnd_cycle(input bit allow_in);
        logic [15:0] r;
        logic [3:0]  f;
        logic [19:0] e;
        in_valid  = allow_in && ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 4) == 0) aluCode = 4'($urandom_range(6, 15));
        else                           aluCode = 4'($urandom_range(0, 5));
        opA = 16'($urandom);
        opB = 16'($urandom);
        if ($urandom_range(0, 5) == 0) opA = 16'h8000;
        if ($urandom_range(0, 5) == 0) opB = 16'h7FFF;
        if ($urandom_range(0, 7) == 0) opB = opA;
        #1;
        chk("rnd_out_valid", out_valid, exp_q.size() != 0);
        chk("rnd_in_ready", in_ready, (exp_q.size() == 0) || out_ready);
        if (out_valid && out_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rnd_result", result, e[19:4]);
            chk("rnd_flags", flags, e[3:0]);
        end
        if (in_valid && in_ready) begin
            model(aluCode, opA, opB, r, f);
            exp_q.push_back({r, f});
            if (counted(aluCode) && cnt < 65535) cnt++;
        end
        tick();
        chk("rnd_op_count", op_count, cnt);
    endtask

    initial begin
        tbl[0]  = '{4'h2, 16'h0003, 16'h0005, 16'hFFFE, 4'b0010};
        tbl[1]  = '{4'h5, 16'hFFFF, 16'h0001, 16'h0001, 4'b0000};
        tbl[2]  = '{4'h3, 16'hF0F0, 16'h0F0F, 16'h0000, 4'b0001};
        tbl[3]  = '{4'h4, 16'h1234, 16'h00F0, 16'h12F4, 4'b0000};
        tbl[4]  = '{4'h1, 16'hFFFF, 16'h0001, 16'h0000, 4'b0011};
        tbl[5]  = '{4'h2, 16'h8000, 16'h0001, 16'h7FFF, 4'b0100};
        tbl[6]  = '{4'h1, 16'h8000, 16'h8000, 16'h0000, 4'b0111};
        tbl[7]  = '{4'h5, 16'h0001, 16'hFFFF, 16'h0000, 4'b0001};
        tbl[8]  = '{4'h2, 16'h0005, 16'h0005, 16'h0000, 4'b0001};
        tbl[9]  = '{4'h8, 16'h0001, 16'h0002, 16'h0000, 4'b1000};
        tbl[10] = '{4'h0, 16'h0001, 16'h0002, 16'h0000, 4'b0000};
        tbl[11] = '{4'hF, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b1000};
        tbl[12] = '{4'h2, 16'h7FFF, 16'hFFFF, 16'h8000, 4'b0110};

        // Reset with an operation offered: it must be dropped, ready stays 1.
        reset = 1'b1; in_valid = 1'b1; aluCode = 4'h1; opA = 16'd1; opB = 16'd2; out_ready = 1'b0;
        #1;
        chk("reset_in_ready_pre", in_ready, 1'b1);
        tick();
        tick();
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_result", result, 16'h0000);
        chk("reset_flags", flags, 4'h0);
        chk("reset_op_count", op_count, 16'd0);
        chk("reset_in_ready", in_ready, 1'b1);

        // First add: overflow case.
        reset = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; aluCode = 4'h1; opA = 16'h7FFF; opB = 16'h0001;
        tick();
        chk("add_ovf_valid", out_valid, 1'b1);
        chk("add_ovf_result", result, 16'h8000);
        chk("add_ovf_flags", flags, 4'b0100);
        chk("add_ovf_count", op_count, 16'd1);
        cnt = 1;
        in_valid = 1'b0;
        tick();
        chk("add_ovf_drain", out_valid, 1'b0);

        // Directed table, back-to-back with a ready consumer.
        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1; aluCode = tbl[i].code; opA = tbl[i].a; opB = tbl[i].b;
            tick();
            chk("tbl_valid", out_valid, 1'b1);
            chk("tbl_result", result, tbl[i].r);
            chk("tbl_flags", flags, tbl[i].f);
            if (counted(tbl[i].code)) cnt++;
            chk("tbl_op_count", op_count, cnt);
        end
        in_valid = 1'b0;
        tick();
        chk("tbl_drain", out_valid, 1'b0);

        // Random traffic against the model, then drain.
        for (int n = 0; n < 400; n++) rnd_cycle(1'b1);
        for (int n = 0; n < 8; n++) rnd_cycle(1'b0);
        out_ready = 1'b1;
        tick();
        chk("rnd_empty", out_valid, 1'b0);
        exp_q.delete();

        // Backpressure: hold 2+3 while a second offer waits.
        out_ready = 1'b0; in_valid = 1'b1; aluCode = 4'h1; opA = 16'd2; opB = 16'd3;
        tick();
        cnt++;
        chk("bp_valid", out_valid, 1'b1);
        chk("bp_result", result, 16'd5);
        aluCode = 4'h4; opA = 16'd1; opB = 16'd2;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_in_ready_low", in_ready, 1'b0);
            tick();
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_result", result, 16'd5);
            chk("bp_hold_flags", flags, 4'b0000);
            chk("bp_hold_count", op_count, cnt);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_high", in_ready, 1'b1);
        tick();
        cnt++;
        chk("bp_second_valid", out_valid, 1'b1);
        chk("bp_second_result", result, 16'd3);
        chk("bp_second_count", op_count, cnt);
        in_valid = 1'b0;
        tick();
        chk("bp_drain", out_valid, 1'b0);

        // Back-to-back: four ops from a fresh reset.
        reset = 1'b1;
        tick();
        reset = 1'b0; cnt = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            aluCode = 4'h1; opA = 16'(k * 10); opB = 16'd1;
            tick();
            chk("b2b_valid", out_valid, 1'b1);
            chk("b2b_result", result, 16'(k * 10 + 1));
        end
        in_valid = 1'b0;
        chk("b2b_count", op_count, 16'd4);
        tick();
        chk("b2b_drain", out_valid, 1'b0);

        // Reset while holding a result.
        out_ready = 1'b0; in_valid = 1'b1; aluCode = 4'h1; opA = 16'd1; opB = 16'd1;
        tick();
        chk("rh_full", out_valid, 1'b1);
        in_valid = 1'b0; reset = 1'b1;
        tick();
        chk("rh_valid", out_valid, 1'b0);
        chk("rh_count", op_count, 16'd0);
        chk("rh_result", result, 16'd0);
        chk("rh_flags", flags, 4'h0);
        reset = 1'b0; out_ready = 1'b1;
        tick();
        chk("rh_after", out_valid, 1'b0);

        // Drive the counter to saturation, then one more add.
        in_valid = 1'b1; out_ready = 1'b1; aluCode = 4'h1; opA = 16'd1; opB = 16'd1;
        repeat (65535) @(posedge clk);
        #1;
        chk("sat_reach", op_count, 16'hFFFF);
        aluCode = 4'h2;
        tick();
        chk("sat_hold", op_count, 16'hFFFF);
        chk("sat_result", result, 16'd0);
        chk("sat_flags", flags, 4'b0001);
        in_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu_exec
